// File: rtl/product_accumulator.sv
// Frame accumulator for the multiplier output stream: sums one frame of 2n-bit
// products (sign- or zero-extended per frame) and offers the total on a valid/ready port.
module product_accumulator #(
    parameter int n       = 8,
    parameter int max_len = 16,
    parameter int w       = 2 * n + $clog2(max_len),
    parameter int cw      = $clog2(max_len + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [2*n-1:0]  up_prod,
    input  logic            up_signed,
    input  logic            up_last,
    output logic            down_valid,
    input  logic            down_ready,
    output logic [w-1:0]    down_sum,
    output logic [cw-1:0]   down_count,
    output logic            down_signed,
    output logic            down_trunc
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [cw-1:0] MAX_CNT = cw'(max_len);

    state_t          r_state;
    state_t          w_state_next;

    logic [w-1:0]    r_acc;
    logic [cw-1:0]   r_count;
    logic            r_sign;

    logic [w-1:0]    r_down_sum;
    logic [cw-1:0]   r_down_count;
    logic            r_down_signed;
    logic            r_down_trunc;

    logic            w_fire;
    logic            w_first;
    logic            w_sign;
    logic [w-1:0]    w_ext;
    logic [w-1:0]    w_sum;
    logic [cw-1:0]   w_count_inc;
    logic            w_hit_max;
    logic            w_close;
    logic            w_release;

    // Handshake qualifiers: up_ready depends only on state and reset.
    assign up_ready   = (r_state == ST_ACC) && !rst;
    assign down_valid = (r_state == ST_HOLD);
    assign w_fire     = up_valid && up_ready;
    assign w_release  = (r_state == ST_HOLD) && down_ready;

    // The first beat of a frame supplies its own signedness; later beats use the latched one.
    assign w_first = (r_count == '0);
    assign w_sign  = w_first ? up_signed : r_sign;

    generate
        if (w > 2 * n) begin : g_extend
            assign w_ext = {{(w - 2 * n){w_sign & up_prod[2*n-1]}}, up_prod};
        end else begin : g_no_extend
            assign w_ext = up_prod;
        end
    endgenerate

    assign w_sum       = r_acc + w_ext;
    assign w_count_inc = r_count + cw'(1);
    assign w_hit_max   = (w_count_inc == MAX_CNT);
    assign w_close     = w_fire && (up_last || w_hit_max);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_ACC:  if (w_close)   w_state_next = ST_HOLD;
            ST_HOLD: if (w_release) w_state_next = ST_ACC;
            default: w_state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Running frame state; cleared once the held result has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sign  <= 1'b0;
        end else if (w_release) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sign  <= 1'b0;
        end else if (w_fire) begin
            r_acc   <= w_sum;
            r_count <= w_count_inc;
            r_sign  <= w_sign;
        end
    end

    // Result registers load only on the closing beat, so they stay put through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_down_sum    <= '0;
            r_down_count  <= '0;
            r_down_signed <= 1'b0;
            r_down_trunc  <= 1'b0;
        end else if (w_close) begin
            r_down_sum    <= w_sum;
            r_down_count  <= w_count_inc;
            r_down_signed <= w_sign;
            r_down_trunc  <= !up_last;
        end
    end

    assign down_sum    = r_down_sum;
    assign down_count  = r_down_count;
    assign down_signed = r_down_signed;
    assign down_trunc  = r_down_trunc;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (n=4, max_len=4): a reference model pushes
// expected frame results to a scoreboard that a negedge monitor pops on each handshake.
module tb_product_accumulator;

    localparam int N   = 4;
    localparam int MAX = 4;
    localparam int W   = 2 * N + $clog2(MAX);
    localparam int CW  = $clog2(MAX + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            up_valid = 1'b0;
    logic            up_ready;
    logic [2*N-1:0]  up_prod = '0;
    logic            up_signed = 1'b0;
    logic            up_last = 1'b0;
    logic            down_valid;
    logic            down_ready = 1'b1;
    logic [W-1:0]    down_sum;
    logic [CW-1:0]   down_count;
    logic            down_signed;
    logic            down_trunc;

    product_accumulator #(.n(N), .max_len(MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_prod     (up_prod),
        .up_signed   (up_signed),
        .up_last     (up_last),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .down_sum    (down_sum),
        .down_count  (down_count),
        .down_signed (down_signed),
        .down_trunc  (down_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  sum;
        logic [CW-1:0] count;
        logic          sgn;
        logic          trunc;
    } exp_t;

    exp_t sb[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    int m_acc   = 0;
    int m_count = 0;
    logic m_sign = 1'b0;
    int last_accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat starting just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2*N-1:0] prod, input logic sgn, input logic last);
        logic accepted;
        int   v;
        accepted  = 1'b0;
        up_valid  = 1'b1;
        up_prod   = prod;
        up_signed = sgn;
        up_last   = last;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (up_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check("send_accept", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_last  = 1'b0;
        if (accepted) begin
            last_accept_cyc = cyc;
            if (m_count == 0) m_sign = sgn;
            v = m_sign ? int'($signed(prod)) : int'(prod);
            m_acc   = m_acc + v;
            m_count = m_count + 1;
            if (last || m_count == MAX) begin
                sb.push_back('{sum: W'(m_acc), count: CW'(m_count), sgn: m_sign, trunc: !last});
                $display("push sum=%0h count=%0d signed=%0b trunc=%0b",
                         W'(m_acc), m_count, m_sign, !last);
                m_acc   = 0;
                m_count = 0;
            end
        end
    endtask

    // Scoreboard monitor: one line per completed result handshake.
    always @(negedge clk) begin
        if (!rst && down_valid && down_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 32'(down_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result sum=%0h count=%0d signed=%0b trunc=%0b", down_sum, down_count,
                         down_signed, down_trunc);
                check("sb_sum",    32'(down_sum),    32'(e.sum));
                check("sb_count",  32'(down_count),  32'(e.count));
                check("sb_signed", 32'(down_signed), 32'(e.sgn));
                check("sb_trunc",  32'(down_trunc),  32'(e.trunc));
            end
        end
    end

    initial begin
        logic [2*N-1:0] p;
        logic           s;
        int             prev_cyc;

        // Reset state
        sync();
        sync();
        check("rst_up_ready",    32'(up_ready),    32'd0);
        check("rst_down_valid",  32'(down_valid),  32'd0);
        check("rst_down_sum",    32'(down_sum),    32'd0);
        check("rst_down_count",  32'(down_count),  32'd0);
        check("rst_down_signed", 32'(down_signed), 32'd0);
        check("rst_down_trunc",  32'(down_trunc),  32'd0);
        rst = 1'b0;
        sync();
        check("post_rst_up_ready", 32'(up_ready), 32'd1);

        // Unsigned frame of four 8'hE1 beats
        send(8'hE1, 1'b0, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        check("uns_no_early_valid", 32'(down_valid), 32'd0);
        send(8'hE1, 1'b0, 1'b1);
        check("uns_valid_latency", 32'(down_valid), 32'd1);
        check("uns_sum",   32'(down_sum),   32'd900);
        check("uns_count", 32'(down_count), 32'd4);
        check("uns_trunc", 32'(down_trunc), 32'd0);
        check("uns_up_ready_hold", 32'(up_ready), 32'd0);
        sync();

        // Same bits, signed vs unsigned, with up_signed toggled on beat 2
        send(8'h90, 1'b1, 1'b0);
        send(8'h90, 1'b1, 1'b1);
        check("sgn_sum", 32'(down_sum), 32'h320);
        check("sgn_flag", 32'(down_signed), 32'd1);
        sync();
        send(8'h90, 1'b0, 1'b0);
        send(8'h90, 1'b0, 1'b1);
        check("uns90_sum", 32'(down_sum), 32'h120);
        sync();
        send(8'h90, 1'b1, 1'b0);
        send(8'h90, 1'b0, 1'b1);
        check("toggle_sgn_sum", 32'(down_sum), 32'h320);
        check("toggle_sgn_flag", 32'(down_signed), 32'd1);
        sync();
        send(8'h90, 1'b0, 1'b0);
        send(8'h90, 1'b1, 1'b1);
        check("toggle_uns_sum", 32'(down_sum), 32'h120);
        sync();

        // Truncation at max_len, then the fifth beat opens a new frame
        for (int i = 0; i < MAX; i++) send(8'h01, 1'b0, 1'b0);
        check("trunc_flag",  32'(down_trunc), 32'd1);
        check("trunc_count", 32'(down_count), 32'd4);
        check("trunc_sum",   32'(down_sum),   32'd4);
        sync();
        send(8'h01, 1'b0, 1'b1);
        check("after_trunc_count", 32'(down_count), 32'd1);
        check("after_trunc_sum",   32'(down_sum),   32'd1);
        check("after_trunc_flag",  32'(down_trunc), 32'd0);
        sync();

        // last on the max_len beat is not a truncation
        for (int i = 0; i < MAX; i++) send(8'hFF, 1'b1, i == MAX - 1);
        check("last_at_max_trunc", 32'(down_trunc), 32'd0);
        sync();

        // Backpressure: result held, upstream stalled while a beat is offered
        down_ready = 1'b0;
        send(8'h33, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b1);
        up_valid = 1'b1;
        up_prod  = 8'h7F;
        up_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sync();
            check("bp_valid",    32'(down_valid), 32'd1);
            check("bp_up_ready", 32'(up_ready),   32'd0);
            check("bp_sum",      32'(down_sum),   32'h066);
            check("bp_count",    32'(down_count), 32'd2);
        end
        up_valid   = 1'b0;
        up_last    = 1'b0;
        down_ready = 1'b1;
        sync();
        check("bp_release_up_ready", 32'(up_ready),   32'd1);
        check("bp_release_valid",    32'(down_valid), 32'd0);

        // Reset mid-frame discards the partial sum
        send(8'h10, 1'b0, 1'b0);
        send(8'h10, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_up_ready", 32'(up_ready), 32'd0);
        sync();
        rst = 1'b0;
        m_acc   = 0;
        m_count = 0;
        check("rst_mid_no_valid", 32'(down_valid), 32'd0);
        send(8'h05, 1'b0, 1'b1);
        check("rst_mid_sum",   32'(down_sum),   32'd5);
        check("rst_mid_count", 32'(down_count), 32'd1);
        sync();

        // Back-to-back single-beat frames: one result every two cycles
        send(8'h00, 1'b0, 1'b1);
        prev_cyc = last_accept_cyc;
        for (int i = 0; i < 6; i++) begin
            p = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            send(p, s, 1'b1);
            check("b2b_spacing", 32'(last_accept_cyc - prev_cyc), 32'd2);
            prev_cyc = last_accept_cyc;
        end
        sync();
        sync();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
